// File: rtl/tone_sequencer.sv
// Note memory and playback engine: records switch tones on write, replays them while read is held.
// Define TONE_SEQ_GAP_EN to insert GAP_TICKS of silence between consecutive notes.
module tone_sequencer #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int NOTE_TICKS = 25_000_000,
  parameter int GAP_TICKS  = 2_500_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              write,
  input  logic              read,
  input  logic [7:0]        swTones,
  output logic [7:0]        tone_out,
  output logic              finish,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam int TMAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]   NOTE_LAST = TW'(NOTE_TICKS - 1);
`ifdef TONE_SEQ_GAP_EN
  localparam logic [TW-1:0]   GAP_LAST  = TW'(GAP_TICKS - 1);
`endif
  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C     = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
`ifdef TONE_SEQ_GAP_EN
    S_GAP,
`endif
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                finish_q, finish_d;
  logic [7:0]          mem_q [DEPTH];
  logic                wr_en;
  logic                last_note;

  assign full      = (count_q == DEPTH_C);
  assign count     = count_q;
  assign finish    = finish_q;
  assign wr_en     = write && !clear && !full && (state_q == S_IDLE);
  assign last_note = ({1'b0, rd_q} == (count_q - ONE_C));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_q     <= '0;
      tick_q   <= '0;
      count_q  <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      tick_q   <= tick_d;
      count_q  <= count_d;
      finish_q <= finish_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wr_en) mem_q[count_q[ADDR_W-1:0]] <= swTones;
  end

  // Empty check uses the post-clear/post-write count so rd_addr never passes count-1.
  always_comb begin
    count_d = count_q;
    if (state_q == S_IDLE) begin
      if (clear)      count_d = '0;
      else if (wr_en) count_d = count_q + ONE_C;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    tick_d  = tick_q;
    case (state_q)
      S_IDLE: begin
        if (read) begin
          state_d = (count_d == '0) ? S_DONE : S_PLAY;
          rd_d    = '0;
          tick_d  = '0;
        end
      end
      S_PLAY: begin
        if (!read) begin
          state_d = S_IDLE;
        end else if (tick_q == NOTE_LAST) begin
          if (last_note) begin
            state_d = S_DONE;
          end else begin
            tick_d = '0;
`ifdef TONE_SEQ_GAP_EN
            state_d = S_GAP;
`else
            rd_d = rd_q + 1'b1;
`endif
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`ifdef TONE_SEQ_GAP_EN
      S_GAP: begin
        if (!read) begin
          state_d = S_IDLE;
        end else if (tick_q == GAP_LAST) begin
          state_d = S_PLAY;
          rd_d    = rd_q + 1'b1;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`endif
      S_DONE: begin
        if (!read) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    finish_d = (state_d == S_DONE) && (state_q != S_DONE);
    case (state_q)
      S_IDLE:  tone_out = swTones;
      S_PLAY:  tone_out = mem_q[rd_q];
      default: tone_out = '0;
    endcase
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: directed vector table, note-sequence checks and random run vs. a schedule model.
module tb_tone_sequencer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int NT    = 3;
  localparam int GT    = 2;
`ifdef TONE_SEQ_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, clear, write, read;
  logic [7:0]    swTones, tone_out;
  logic          finish;
  logic [AW:0]   count;
  logic          full;

  tone_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW), .NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .clock(clock), .reset(reset), .clear(clear), .write(write), .read(read),
    .swTones(swTones), .tone_out(tone_out), .finish(finish), .count(count), .full(full)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Model: stored notes as a queue; playback as a precomputed per-cycle tone schedule.
  logic [7:0] stored[$];
  logic [7:0] sched[$];
  int         mode;   // 0 idle, 1 playing, 2 done-waiting-for-release
  bit         m_fin;

  function automatic void model_edge(bit r, bit c, bit w, bit rd, logic [7:0] sw);
    bit fin_n;
    fin_n = 1'b0;
    if (r) begin
      stored.delete(); sched.delete(); mode = 0; m_fin = 1'b0;
      return;
    end
    case (mode)
      0: begin
        if (c) stored.delete();
        else if (w && stored.size() < DEPTH) stored.push_back(sw);
        if (rd) begin
          if (stored.size() == 0) begin
            mode = 2; fin_n = 1'b1;
          end else begin
            sched.delete();
            foreach (stored[i]) begin
              repeat (NT) sched.push_back(stored[i]);
              if (GAP_EN && i != stored.size() - 1) repeat (GT) sched.push_back(8'h00);
            end
            mode = 1;
          end
        end
      end
      1: begin
        if (!rd) begin
          mode = 0; sched.delete();
        end else begin
          void'(sched.pop_front());
          if (sched.size() == 0) begin mode = 2; fin_n = 1'b1; end
        end
      end
      default: if (!rd) mode = 0;
    endcase
    m_fin = fin_n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit c, input bit w, input bit rd, input logic [7:0] sw);
    logic [7:0] et;
    reset = r; clear = c; write = w; read = rd; swTones = sw;
    @(posedge clock);
    model_edge(r, c, w, rd, sw);
    @(negedge clock);
    if (mode == 0)      et = sw;
    else if (mode == 1) et = sched[0];
    else                et = 8'h00;
    chk("model_tone",   tone_out, et);
    chk("model_finish", finish, m_fin);
    chk("model_count",  count, stored.size());
    chk("model_full",   full, stored.size() == DEPTH);
  endtask

  // Record notes, then hold read and check every cycle of the expected tone sequence.
  task automatic play_check(input logic [7:0] notes[$], input int n_writes);
    logic [7:0] expv[$];
    int         kept;
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < n_writes; i++) step(0, 0, 1, 0, notes[i]);
    kept = (n_writes > DEPTH) ? DEPTH : n_writes;
    chk("seq_count", count, kept);
    chk("seq_full",  full, kept == DEPTH);
    for (int i = 0; i < kept; i++) begin
      repeat (NT) expv.push_back(notes[i]);
      if (GAP_EN && i != kept - 1) repeat (GT) expv.push_back(8'h00);
    end
    for (int k = 0; k <= expv.size(); k++) begin
      step(0, 0, 0, 1, 8'hFF);
      if (k < expv.size()) begin
        chk("seq_tone", tone_out, expv[k]);
        chk("seq_finish_low", finish, 1'b0);
      end else begin
        chk("seq_finish_pulse", finish, 1'b1);
        chk("seq_done_tone", tone_out, 8'h00);
      end
    end
    step(0, 0, 0, 1, 8'hFF);
    chk("seq_finish_single", finish, 1'b0);
    step(0, 0, 0, 0, 8'h3C);
    chk("seq_idle_tone", tone_out, 8'h3C);
  endtask

  typedef struct {
    bit r, c, w, rd;
    logic [7:0] sw;
    logic [7:0] t;
    bit f;
    logic [AW:0] cnt;
    bit fl;
  } vec_t;

  vec_t tbl[24];

  initial begin
    logic [7:0] nq[$];
    bit rd_lvl;
    reset = 1'b1; clear = 1'b0; write = 1'b0; read = 1'b0; swTones = 8'h00;
    mode = 0; m_fin = 1'b0;

    //          r  c  w  rd  sw     tone   f  cnt fl
    tbl[0]  = '{1, 0, 0, 0, 8'h55, 8'h55, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 8'h01, 8'h01, 0, 1, 0};
    tbl[2]  = '{0, 0, 1, 0, 8'h02, 8'h02, 0, 2, 0};
    tbl[3]  = '{0, 0, 1, 0, 8'h03, 8'h03, 0, 3, 0};
    tbl[4]  = '{0, 0, 1, 0, 8'h04, 8'h04, 0, 4, 1};
    tbl[5]  = '{0, 0, 1, 0, 8'h05, 8'h05, 0, 4, 1};
    tbl[6]  = '{0, 1, 1, 0, 8'hAA, 8'hAA, 0, 0, 0};
    tbl[7]  = '{0, 0, 1, 0, 8'h11, 8'h11, 0, 1, 0};
    tbl[8]  = '{0, 0, 1, 0, 8'h22, 8'h22, 0, 2, 0};
    tbl[9]  = '{0, 1, 1, 0, 8'h33, 8'h33, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 8'h77, 8'h00, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 1, 8'h77, 8'h00, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 1, 8'h77, 8'h00, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 8'h99, 8'h99, 0, 0, 0};
    tbl[14] = '{0, 0, 1, 0, 8'h12, 8'h12, 0, 1, 0};
    tbl[15] = '{0, 0, 0, 1, 8'h00, 8'h12, 0, 1, 0};
    tbl[16] = '{0, 0, 0, 1, 8'h00, 8'h12, 0, 1, 0};
    tbl[17] = '{0, 0, 0, 1, 8'h00, 8'h12, 0, 1, 0};
    tbl[18] = '{0, 0, 0, 1, 8'h00, 8'h00, 1, 1, 0};
    tbl[19] = '{0, 0, 0, 0, 8'h40, 8'h40, 0, 1, 0};
    tbl[20] = '{0, 0, 0, 1, 8'h40, 8'h12, 0, 1, 0};
    tbl[21] = '{0, 0, 0, 0, 8'h41, 8'h41, 0, 1, 0};
    tbl[22] = '{0, 0, 0, 0, 8'h41, 8'h41, 0, 1, 0};
    tbl[23] = '{1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0};

    @(negedge clock);
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].w, tbl[i].rd, tbl[i].sw);
      chk($sformatf("tbl%0d_tone", i),   tone_out, tbl[i].t);
      chk($sformatf("tbl%0d_finish", i), finish,   tbl[i].f);
      chk($sformatf("tbl%0d_count", i),  count,    tbl[i].cnt);
      chk($sformatf("tbl%0d_full", i),   full,     tbl[i].fl);
    end

    nq = '{8'h01, 8'h04, 8'h10};
    play_check(nq, 3);
    nq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    play_check(nq, 5);
    nq = '{8'h02, 8'h08};
    play_check(nq, 2);

    // Abort mid-note, then reset mid-play.
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 8'h33);
    step(0, 0, 1, 0, 8'h44);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 8'h5A);
    chk("abort_tone",   tone_out, 8'h5A);
    chk("abort_finish", finish, 1'b0);
    chk("abort_count",  count, 2);
    step(0, 0, 0, 1, 8'h00);
    chk("replay_tone", tone_out, 8'h33);
    step(0, 0, 0, 1, 8'h00);
    step(1, 0, 0, 1, 8'h66);
    chk("rst_count",  count, 0);
    chk("rst_finish", finish, 1'b0);
    chk("rst_tone",   tone_out, 8'h66);
    step(0, 0, 0, 0, 8'h00);

    rd_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) rd_lvl = ~rd_lvl;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) == 0, rd_lvl, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Note memory and playback engine directly downstream of the record/playback control FSM. Stores the 8-bit switch tone pattern on each `write` pulse and, while `read` is held, replays the stored tones in order at a fixed note duration. When the last note ends it returns a one-cycle `finish` pulse to the control FSM. `tone_out` feeds the tone generator: live switches while idle, stored notes during playback.

## Interface
- `DEPTH`, 16: number of note slots.
- `ADDR_W`, 4: address width; `2**ADDR_W == DEPTH`.
- `NOTE_TICKS`, 25_000_000: clock cycles each note is held (≥1).
- `GAP_TICKS`, 2_500_000: silent cycles between notes (≥1); used only with `TONE_SEQ_GAP_EN`.

Ports:
- `clock` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `clear` in 1: empties the memory (driven by the start-of-recording event).
- `write` in 1: one-cycle store strobe from the control FSM.
- `read` in 1: playback request level from the control FSM.
- `swTones` in 8: live tone switches.
- `tone_out` out 8: tone to the generator.
- `finish` out 1: registered one-cycle end-of-playback pulse.
- `count` out ADDR_W+1: number of stored notes, 0..DEPTH.
- `full` out 1: `count == DEPTH`.

## Operation
- Storage is a register array `mem[DEPTH]`. `count` also serves as the write pointer.
- Write: if `write` && !`clear` && !`full` && state==IDLE, then `mem[count] <= swTones` and `count <= count+1`. Otherwise the write is dropped silently. Write while full, write during playback, and write coinciding with `clear` are all dropped.
- Clear: `count <= 0` when state is IDLE. `clear` is ignored in other states. Memory contents are left in place.
- Playback FSM:
  - IDLE: `tone_out = swTones`. If `read` && `count==0`, go to DONE with `finish<=1`. If `read` && `count>0`, go to PLAY with `rd_addr<=0`, `tick<=0`.
  - PLAY: `tone_out = mem[rd_addr]`. `tick` increments. At `tick==NOTE_TICKS-1`:
    - If `rd_addr==count-1`, go to DONE with `finish<=1`.
    - Otherwise `rd_addr+1` and `tick<=0`. With gap enabled, go to GAP instead of staying in PLAY.
  - GAP (gap build only): `tone_out = 0`. At `tick==GAP_TICKS-1`, return to PLAY with `rd_addr` incremented and `tick<=0`.
  - DONE: `tone_out = 0`, `finish<=0` after one cycle. Return to IDLE when `read==0`.
- Dropping `read` in PLAY or GAP aborts: go to IDLE, with no `finish` pulse.
- Arithmetic: `tick` is `$clog2(max(NOTE_TICKS,GAP_TICKS))` bits wide and never wraps. `rd_addr` never exceeds `count-1`.

## Timing
- Reset values: state=IDLE, `count=0`, `finish=0`, `rd_addr=0`, `tick=0`. `tone_out` is therefore `swTones` in the first cycle after reset, and `full=0`.
- Reset mid-playback or mid-write takes priority over everything and forces the reset values above on the same edge.
- Write latency: `count`/`full` update on the edge sampling `write`. The stored value is readable on the next cycle.
- Playback latency: the first note appears on `tone_out` in the cycle after the edge that samples `read`=1.
- Each note lasts exactly NOTE_TICKS cycles.
- `finish` is high for exactly one cycle: the first DONE cycle. It rises NOTE_TICKS·N cycles after PLAY entry, or N·NOTE_TICKS+(N−1)·GAP_TICKS with gap.
- Empty memory: `finish` is high in the cycle after `read` is sampled.
- A new playback requires `read` to deassert and reassert.

## Configuration
- `TONE_SEQ_GAP_EN` defined: the GAP state exists and a silence of GAP_TICKS cycles (`tone_out=0`) is inserted between consecutive notes. There is no gap after the last note.
- Not defined: no GAP state. Notes play back-to-back and GAP_TICKS is unused.

## Test plan
All scenarios use DEPTH=4, NOTE_TICKS=3, GAP_TICKS=2.
- Reset, then write pulses with `swTones`=0x01, 0x04, 0x10 → `count`=3, `full`=0. Then `read`=1 → `tone_out` shows 0x01×3, 0x04×3, 0x10×3 cycles, `finish` pulses 1 cycle, then `tone_out`=0.
- Five writes (0x01..0x05) → `count`=4, `full`=1. The fifth write is dropped and playback ends after 0x04.
- `read`=1 with `count`=0 → `finish`=1 in the next cycle only. `read` held high → no second pulse.
- Gap build, two notes 0x02, 0x08 → `tone_out`: 0x02×3, 0x00×2, 0x08×3. `finish` rises 8 cycles after PLAY entry.
- `read` dropped mid-note → IDLE, no `finish`, `tone_out`=`swTones`. Assert `reset` mid-play → `count`=0, `finish`=0.
- `clear` and `write` in the same cycle with `count`=2 → `count`=0, and nothing is stored.
